quad_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 32 +++
 rtl/quad_debounce.sv | 73 +++++++
 rtl/quad_decoder.sv | 111 +++++++++++
 tb/tb_quad_decoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and the quadrature step decoder for quad_decoder.
package quad_pkg;

   typedef enum logic [1:0] {
      StFlush,
      StLoad,
      StRun
   } quad_state_t;

   // Encoder phase as {a, b}.
   typedef logic [1:0] phase_t;

   typedef struct packed {
      logic cw;
      logic ccw;
      logic err;
   } step_t;

   // Classify one filtered phase transition. CW order is 00 -> 01 -> 11 -> 10 -> 00.
   function automatic step_t quad_step(input phase_t prev, input phase_t cur);
      step_t res;
      res = '0;
      case ({prev, cur})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: res.cw  = 1'b1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: res.ccw = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: res.err = 1'b1;
         default:                                res     = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/quad_debounce.sv
// Per-channel debounce filter. Counters exist only when QUAD_DEBOUNCE_EN is defined;
// otherwise dout is a plain registered copy of din.
module quad_debounce
   import quad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic load_val,
   input  logic din,
   output logic dout
);

   logic stable_q, stable_d;

`ifdef QUAD_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive mismatching cycles; any return to the stable level restarts the count.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (load) begin
         stable_d = load_val;
         cnt_d    = '0;
      end else if (din == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         stable_d = din;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter and filtered level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end
`else
   // Sizing parameters have no effect in this build.
   logic unused_cfg;
   assign unused_cfg = ^{32'(DEBOUNCE_CYCLES), 32'(CNT_W)};

   // Without filtering the stable level simply tracks the synchronised input.
   always_comb begin
      stable_d = load ? load_val : din;
   end

   // Filtered level register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b0;
      end else begin
         stable_q <= stable_d;
      end
   end
`endif

   assign dout = stable_q;

endmodule

// File: rtl/quad_decoder.sv
// Rotary encoder front-end: 2-FF synchroniser, per-channel debounce and x4 quadrature
// decode into registered one-cycle cw/ccw/err pulses.
// Optional feature macro: QUAD_DEBOUNCE_EN enables the debounce counters.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic cw,
   output logic ccw,
   output logic err
);

   phase_t      s1_q, s1_d, s2_q, s2_d;
   phase_t      prev_q, prev_d, cur;
   quad_state_t state_q, state_d;
   logic        flush_q, flush_d;
   step_t       out_q, out_d;
   logic        load;
   logic        stable_a, stable_b;

   quad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_a (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (s2_q[1]),
      .din      (s2_q[1]),
      .dout     (stable_a)
   );

   quad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_b (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (s2_q[0]),
      .din      (s2_q[0]),
      .dout     (stable_b)
   );

   assign cur = {stable_a, stable_b};

   // Synchroniser next state for the raw asynchronous channels.
   always_comb begin
      s1_d = {a, b};
      s2_d = s1_q;
   end

   // Sequencer: flush the synchroniser, load the resting phase, then decode every cycle.
   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      prev_d  = prev_q;
      out_d   = '0;
      load    = 1'b0;
      unique case (state_q)
         StFlush: begin
            flush_d = 1'b1;
            if (flush_q) begin
               flush_d = 1'b0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            // Adopt the resting phase so a non-00 encoder position does not decode as a step.
            load    = 1'b1;
            prev_d  = s2_q;
            state_d = StRun;
         end
         StRun: begin
            prev_d = cur;
            out_d  = quad_step(prev_q, cur);
         end
         default: state_d = StFlush;
      endcase
   end

   // All state registers, cleared synchronously.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         prev_q  <= '0;
         state_q <= StFlush;
         flush_q <= 1'b0;
         out_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         flush_q <= flush_d;
         out_q   <= out_d;
      end
   end

   assign cw  = out_q.cw;
   assign ccw = out_q.ccw;
   assign err = out_q.err;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder with a time-based behavioural reference model.
module tb_quad_decoder;

   localparam int unsigned DebCycles = 4;
`ifdef QUAD_DEBOUNCE_EN
   localparam int Eff = 4;
`else
   localparam int Eff = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic a = 1'b0;
   logic b = 1'b0;
   logic cw, ccw, err;

   int vectors = 0;
   int miscompares = 0;

   quad_decoder #(
      .DEBOUNCE_CYCLES (DebCycles)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .cw    (cw),
      .ccw   (ccw),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Reference model: raw level delayed two cycles, accepted after Eff mismatching cycles,
   // phase position along the CW cycle compared modulo 4.
   logic [1:0] m_r1, m_r2, m_filt, m_prev;
   int         m_run [2];
   int         m_since;
   logic       m_cw, m_ccw, m_err;
   int         pos_of [4] = '{0, 1, 3, 2};
   logic [1:0] cw_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   always @(posedge clk) begin
      if (reset) begin
         m_r1 <= '0; m_r2 <= '0; m_filt <= '0; m_prev <= '0;
         m_run[0] <= 0; m_run[1] <= 0; m_since <= 0;
         m_cw <= 1'b0; m_ccw <= 1'b0; m_err <= 1'b0;
      end else begin
         m_since <= m_since + 1;
         m_r1 <= {a, b};
         m_r2 <= m_r1;
         m_cw <= 1'b0; m_ccw <= 1'b0; m_err <= 1'b0;
         if (m_since == 2) begin
            m_filt <= m_r2; m_prev <= m_r2;
            m_run[0] <= 0; m_run[1] <= 0;
         end else begin
            for (int c = 0; c < 2; c++) begin
               if (m_r2[c] == m_filt[c]) m_run[c] <= 0;
               else if (m_run[c] + 1 >= Eff) begin
                  m_filt[c] <= m_r2[c];
                  m_run[c] <= 0;
               end else m_run[c] <= m_run[c] + 1;
            end
            if (m_since >= 3) begin
               m_prev <= m_filt;
               case ((pos_of[m_filt] - pos_of[m_prev] + 4) % 4)
                  1: m_cw <= 1'b1;
                  3: m_ccw <= 1'b1;
                  2: m_err <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic reset_dut(input logic [1:0] ab);
      @(negedge clk);
      {a, b} = ab;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset;
      int pulses = 0;
      reset = 1'b1;
      {a, b} = 2'b11;
      repeat (3) @(negedge clk);
      vectors++;
      if ({cw, ccw, err} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_values: cw/ccw/err=%b%b%b, required 000", cw, ccw, err);
      end
      reset = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         pulses += int'(cw) + int'(ccw) + int'(err);
         vectors++;
         if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
            miscompares++;
            $display("FAIL reset_rest @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                     $time, cw, ccw, err, m_cw, m_ccw, m_err);
         end
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL reset_rest_quiet: pulses=%0d, required 0", pulses);
      end
   endtask

   task automatic test_cw_sequence;
      int n_cw = 0, n_other = 0, lat;
      reset_dut(2'b00);
      for (int i = 0; i < 4; i++) begin
         {a, b} = cw_seq[(i + 1) % 4];
         lat = -1;
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (cw && lat < 0) lat = t;
            n_cw += int'(cw);
            n_other += int'(ccw) + int'(err);
            vectors++;
            if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
               miscompares++;
               $display("FAIL cw_seq @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                        $time, cw, ccw, err, m_cw, m_ccw, m_err);
            end
         end
         vectors++;
         if (lat !== 2 + Eff) begin
            miscompares++;
            $display("FAIL cw_latency step %0d: latency=%0d, required %0d", i, lat, 2 + Eff);
         end
      end
      vectors++;
      if (n_cw !== 4 || n_other !== 0) begin
         miscompares++;
         $display("FAIL cw_count: cw=%0d other=%0d, required 4/0", n_cw, n_other);
      end
   endtask

   task automatic test_ccw_sequence;
      int n_ccw = 0, n_other = 0;
      reset_dut(2'b00);
      for (int i = 3; i >= 0; i--) begin
         {a, b} = cw_seq[i];
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_ccw += int'(ccw);
            n_other += int'(cw) + int'(err);
            vectors++;
            if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
               miscompares++;
               $display("FAIL ccw_seq @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                        $time, cw, ccw, err, m_cw, m_ccw, m_err);
            end
         end
      end
      vectors++;
      if (n_ccw !== 4 || n_other !== 0) begin
         miscompares++;
         $display("FAIL ccw_count: ccw=%0d other=%0d, required 4/0", n_ccw, n_other);
      end
   endtask

   task automatic test_bounce;
      int glen, gap, n_glitch = 0, exp_glitch = 0, n_hold_ccw = 0, n_hold_other = 0;
      reset_dut(2'b00);
      for (int g = 0; g < 5; g++) begin
         glen = $urandom_range(1, 3);
         gap = $urandom_range(2, 6);
         exp_glitch += (glen >= Eff) ? 2 : 0;
         for (int t = 0; t < glen + gap + ((g == 4) ? 8 : 0); t++) begin
            a = (t < glen);
            @(negedge clk);
            n_glitch += int'(cw) + int'(ccw) + int'(err);
            vectors++;
            if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
               miscompares++;
               $display("FAIL bounce @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                        $time, cw, ccw, err, m_cw, m_ccw, m_err);
            end
         end
      end
      vectors++;
      if (n_glitch !== exp_glitch) begin
         miscompares++;
         $display("FAIL bounce_reject: pulses=%0d, required %0d", n_glitch, exp_glitch);
      end
      a = 1'b1;
      for (int t = 0; t < 15; t++) begin
         @(negedge clk);
         n_hold_ccw += int'(ccw);
         n_hold_other += int'(cw) + int'(err);
         vectors++;
         if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
            miscompares++;
            $display("FAIL bounce_hold @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                     $time, cw, ccw, err, m_cw, m_ccw, m_err);
         end
      end
      vectors++;
      if (n_hold_ccw !== 1 || n_hold_other !== 0) begin
         miscompares++;
         $display("FAIL bounce_hold_count: ccw=%0d other=%0d, required 1/0",
                  n_hold_ccw, n_hold_other);
      end
   endtask

   task automatic test_illegal;
      int n_cw = 0, n_ccw = 0, n_err = 0;
      reset_dut(2'b00);
      for (int t = 0; t < 24; t++) begin
         {a, b} = (t < 12) ? 2'b11 : 2'b10;
         @(negedge clk);
         n_cw += int'(cw); n_ccw += int'(ccw); n_err += int'(err);
         vectors++;
         if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
            miscompares++;
            $display("FAIL illegal @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                     $time, cw, ccw, err, m_cw, m_ccw, m_err);
         end
      end
      vectors++;
      if (n_err !== 1 || n_cw !== 1 || n_ccw !== 0) begin
         miscompares++;
         $display("FAIL illegal_count: err=%0d cw=%0d ccw=%0d, required 1/1/0",
                  n_err, n_cw, n_ccw);
      end
   endtask

   task automatic test_reset_mid;
      int n_quiet = 0, n_cw = 0, n_other = 0;
      reset_dut(2'b00);
      a = 1'b1;
      for (int t = 0; t < 24; t++) begin
         reset = (t == 2 || t == 3);
         @(negedge clk);
         n_quiet += int'(cw) + int'(ccw) + int'(err);
         vectors++;
         if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
            miscompares++;
            $display("FAIL reset_mid @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                     $time, cw, ccw, err, m_cw, m_ccw, m_err);
         end
      end
      vectors++;
      if (n_quiet !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_quiet: pulses=%0d, required 0", n_quiet);
      end
      a = 1'b0;
      for (int t = 0; t < 15; t++) begin
         @(negedge clk);
         n_cw += int'(cw);
         n_other += int'(ccw) + int'(err);
      end
      vectors++;
      if (n_cw !== 1 || n_other !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_adopt: cw=%0d other=%0d, required 1/0", n_cw, n_other);
      end
   endtask

   task automatic test_random_walk;
      int pos = 0, hold;
      reset_dut(2'b00);
      for (int s = 0; s < 60; s++) begin
         pos = (pos + int'($urandom_range(0, 3))) % 4;
         {a, b} = cw_seq[pos];
         hold = $urandom_range(1, 2 * Eff + 3);
         for (int t = 0; t < hold; t++) begin
            @(negedge clk);
            vectors++;
            if ({cw, ccw, err} !== {m_cw, m_ccw, m_err}) begin
               miscompares++;
               $display("FAIL random_walk @%0t: cw/ccw/err=%b%b%b, model %b%b%b",
                        $time, cw, ccw, err, m_cw, m_ccw, m_err);
            end
            vectors++;
            if ($countones({cw, ccw, err}) > 1) begin
               miscompares++;
               $display("FAIL exclusive @%0t: cw/ccw/err=%b%b%b, required at most one",
                        $time, cw, ccw, err);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_cw_sequence();
      test_ccw_sequence();
      test_bounce();
      test_illegal();
      test_reset_mid();
      test_random_walk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
